// File: rtl/multi_blinker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_blinker_if
//  Brief    : Single-cycle configuration write port for multi_blinker.
//  Revision : 1.0
// ============================================================================
interface multi_blinker_if #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic [BURST_W-1:0] cfg_burst;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_period,
        output cfg_duty,
        output cfg_burst
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_period,
        input cfg_duty,
        input cfg_burst
    );
endinterface
`default_nettype wire

// File: rtl/multi_blinker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_blinker
//  Brief    : NCH independent blinker channels, each OFF/ON/BLINK/BURST with
//             runtime period, duty and burst length.
//  Revision : 1.0
// ============================================================================
module multi_blinker #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           enable,
    multi_blinker_if.slave      cfg,
    output logic [NCH-1:0]      blink,
    output logic [NCH-1:0]      wrap,
    output logic [NCH-1:0]      done
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mode_t              mode;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   duty;
        logic [CNT_W-1:0]   cnt;
        logic [BURST_W-1:0] burst_left;
        logic               done_q;
        logic               sel;
        logic               active;
        logic               at_end;
        logic               blink_c;

        // Channel indices >= NCH never match, so such writes are dropped.
        assign sel    = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
        assign active = ((mode == MODE_BLINK) || (mode == MODE_BURST)) && !done_q;
        assign at_end = (cnt == period);

        always_ff @(posedge clk) begin
            if (!rst) begin
                mode       <= MODE_OFF;
                period     <= '0;
                duty       <= '0;
                cnt        <= '0;
                burst_left <= '0;
                done_q     <= 1'b0;
            end else if (sel) begin
                mode       <= mode_t'(cfg.cfg_mode);
                period     <= cfg.cfg_period;
                duty       <= cfg.cfg_duty;
                cnt        <= '0;
                burst_left <= cfg.cfg_burst;
                done_q     <= (cfg.cfg_mode == MODE_BURST) && (cfg.cfg_burst == '0);
            end else if (enable && active) begin
                if (at_end) begin
                    cnt <= '0;
                    if (mode == MODE_BURST) begin
                        // Last pulse of the burst silences the channel.
                        if (burst_left <= BURST_W'(1)) begin
                            burst_left <= '0;
                            done_q     <= 1'b1;
                        end else begin
                            burst_left <= burst_left - BURST_W'(1);
                        end
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        always_comb begin
            blink_c = 1'b0;
            case (mode)
                MODE_OFF:   blink_c = 1'b0;
                MODE_ON:    blink_c = 1'b1;
                MODE_BLINK: blink_c = (cnt < duty);
                MODE_BURST: blink_c = !done_q && (cnt < duty);
                default:    blink_c = 1'b0;
            endcase
        end

        assign blink[i] = blink_c;
        assign wrap[i]  = enable && active && at_end;
        assign done[i]  = done_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_multi_blinker.sv
`timescale 1ns/1ps
// Scoreboard bench for multi_blinker: per-channel reference kept as elapsed
// active cycles since the last write, from which phase and burst state follow.
module tb_multi_blinker;
    localparam int NCH     = 5;
    localparam int CNT_W   = 8;
    localparam int BURST_W = 4;
    localparam int CH_W    = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [NCH-1:0] blink;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] done;

    multi_blinker_if #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_bus ();

    multi_blinker #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .cfg    (cfg_bus),
        .blink  (blink),
        .wrap   (wrap),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] b;
        logic [NCH-1:0] w;
        logic [NCH-1:0] d;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   failed   = 0;
    int   cycle    = 0;

    int m_mode  [NCH];
    int m_per   [NCH];
    int m_duty  [NCH];
    int m_burst [NCH];
    int m_t     [NCH];

    function automatic int m_cnt(int i);
        return m_t[i] % (m_per[i] + 1);
    endfunction

    function automatic bit m_done(int i);
        return (m_mode[i] == 3) && ((m_t[i] / (m_per[i] + 1)) >= m_burst[i]);
    endfunction

    function automatic bit m_active(int i);
        return (m_mode[i] >= 2) && !m_done(i);
    endfunction

    // Advance the reference by one clock edge using the inputs held at that edge.
    task automatic model_update();
        for (int i = 0; i < NCH; i++) begin
            if (rst !== 1'b1) begin
                m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_burst[i] = 0; m_t[i] = 0;
            end else if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) == i) begin
                m_mode[i]  = int'(cfg_bus.cfg_mode);
                m_per[i]   = int'(cfg_bus.cfg_period);
                m_duty[i]  = int'(cfg_bus.cfg_duty);
                m_burst[i] = int'(cfg_bus.cfg_burst);
                m_t[i]     = 0;
            end else if (enable && m_active(i)) begin
                m_t[i] = m_t[i] + 1;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.cyc = cycle;
        for (int i = 0; i < NCH; i++) begin
            e.d[i] = m_done(i);
            e.b[i] = (m_mode[i] == 1) || (m_active(i) && (m_cnt(i) < m_duty[i]));
            e.w[i] = enable && m_active(i) && (m_cnt(i) == m_per[i]);
        end
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit e, input bit w, input int c,
                        input int m, input int p, input int d, input int b);
        @(posedge clk);
        #1;
        cycle++;
        model_update();
        rst                = r;
        enable             = e;
        cfg_bus.cfg_we     = w;
        cfg_bus.cfg_ch     = CH_W'(c);
        cfg_bus.cfg_mode   = 2'(m);
        cfg_bus.cfg_period = CNT_W'(p);
        cfg_bus.cfg_duty   = CNT_W'(d);
        cfg_bus.cfg_burst  = BURST_W'(b);
        push_expected();
    endtask

    task automatic idle(input int n, input bit e);
        repeat (n) step(1'b1, e, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int c, input int m, input int p, input int d, input int b);
        step(1'b1, 1'b1, 1'b1, c, m, p, d, b);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if ({blink, wrap, done} !== {e.b, e.w, e.d}) begin
                failed++;
                $display("FAIL cyc%0d blink/wrap/done got %b/%b/%b expected %b/%b/%b",
                         e.cyc, blink, wrap, done, e.b, e.w, e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: stimulus did not complete in time");
        $display("*** TEST FAILED ***");
        $finish;
    end

    initial begin
        rst = 1'b0; enable = 1'b1;
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = '0; cfg_bus.cfg_mode = 2'd1;
        cfg_bus.cfg_period = '0; cfg_bus.cfg_duty = '0; cfg_bus.cfg_burst = '0;

        // Reset held with a live config write.
        step(1'b0, 1'b1, 1'b1, 0, 1, 3, 2, 1);
        step(1'b0, 1'b1, 1'b1, 1, 2, 3, 2, 1);
        @(negedge clk);
        compared++;
        if ((blink !== '0) || (wrap !== '0) || (done !== '0)) begin
            failed++;
            $display("FAIL reset state: blink/wrap/done got %b/%b/%b expected all zero",
                     blink, wrap, done);
        end
        idle(2, 1'b1);

        // Ch3 ON, ch0 50% square wave.
        wr(3, 1, 0, 0, 0);
        wr(0, 2, 7, 4, 0);
        idle(20, 1'b1);

        // Ch1 burst of three, then a rewrite clears done.
        wr(1, 3, 3, 1, 3);
        idle(16, 1'b1);
        wr(1, 3, 3, 1, 2);
        idle(10, 1'b1);

        // Duty/period corners on ch2.
        wr(2, 2, 0, 1, 0);
        idle(4, 1'b1);
        wr(2, 2, 0, 0, 0);
        idle(3, 1'b1);
        wr(2, 2, 5, 9, 0);
        idle(14, 1'b1);
        wr(2, 3, 5, 9, 0);
        idle(3, 1'b1);

        // Enable low for five cycles mid-period.
        wr(0, 2, 7, 4, 0);
        idle(2, 1'b1);
        idle(5, 1'b0);
        idle(12, 1'b1);

        // Write landing on the wrap cycle, plus writes to absent channels.
        wr(0, 3, 3, 2, 4);
        wr(1, 2, 4, 2, 0);
        idle(2, 1'b1);
        wr(0, 3, 2, 1, 2);
        wr(5, 1, 1, 1, 1);
        wr(6, 3, 0, 0, 0);
        wr(7, 2, 1, 1, 1);
        idle(12, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bit r, e, w;
            int c, m, p, d, b;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 7) == 0);
            c = $urandom_range(0, 7);
            m = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, 255);
                d = $urandom_range(0, 255);
            end else begin
                p = $urandom_range(0, 6);
                d = $urandom_range(0, 9);
            end
            b = $urandom_range(0, 15);
            step(r, e, w, c, m, p, d, b);
        end
        idle(2, 1'b1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        if (failed == 0)
            $display("*** TEST PASSED ***");
        else
            $display("*** TEST FAILED ***");
        $finish;
    end
endmodule
